fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, the PC/instruction-memory address width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, the bubble cycles after a redirect (legal range 1..15).
REQ-003 SHALL have parameter BOOT_CYCLES, default 1, the fetch-inhibit cycles after reset release (legal range 1..15).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  downstream hazard; hold the PC.
REQ-007 SHALL have port redirect  input  1  taken branch/jump resolved this cycle.
REQ-008 SHALL have port redirect_addr  input  ADDR_W  branch/jump target; valid when redirect=1.
REQ-009 SHALL have port halt  input  1  stop fetching (ecall/ebreak).
REQ-010 SHALL have port resume  input  1  leave HALT.
REQ-011 SHALL have port pc_enable  output  1  drives the PC loader enable.
REQ-012 SHALL have port pc_select  output  1  drives the PC loader select; 1 = load jump address.
REQ-013 SHALL have port pc_jump_addr  output  ADDR_W  drives the PC loader jump address.
REQ-014 SHALL have port rom_flush  output  1  drives the instruction ROM flush; forces a NOP.
REQ-015 SHALL have port fetch_valid  output  1  the current ROM instruction is architecturally valid.
REQ-016 SHALL have port fetch_count  output  16  count of valid fetches.
REQ-017 SHALL have port state_o  output  2  current FSM state, for debug.

Function
REQ-018 FSM states SHALL be BOOT=0, RUN=1, FLUSH=2, HALT=3.
REQ-019 Outputs pc_enable, pc_select, pc_jump_addr, rom_flush and fetch_valid SHALL be combinational from the state and current inputs (zero latency), so a redirect loads the PC at the same clock edge.
REQ-020 Input priority SHALL be: reset > redirect > halt > resume > stall.
REQ-021 In BOOT: pc_enable=0, pc_select=0, rom_flush=1 and fetch_valid=0; a 4-bit counter counts BOOT_CYCLES cycles, then the FSM enters RUN; all other inputs are ignored.
REQ-022 In RUN with no event: pc_enable=~stall, pc_select=0, rom_flush=0 and fetch_valid=~stall.
REQ-023 In RUN, FLUSH or HALT with redirect=1: pc_enable=1, pc_select=1, pc_jump_addr=redirect_addr, rom_flush=1 and fetch_valid=0; next state is FLUSH with the counter loaded to FLUSH_CYCLES-1; stall is ignored that cycle.
REQ-024 pc_jump_addr SHALL equal redirect_addr at all times; pc_select gates its use.
REQ-025 In FLUSH with no redirect: pc_enable=~stall, pc_select=0, rom_flush=1 and fetch_valid=0; the counter decrements only when stall=0; at counter=0 with stall=0 the next state is RUN.
REQ-026 In RUN or FLUSH with halt=1 and redirect=0: pc_enable=0, rom_flush=1 and fetch_valid=0; next state is HALT; the FLUSH counter is discarded.
REQ-027 In HALT: pc_enable=0, rom_flush=1 and fetch_valid=0; resume=1 moves the FSM to RUN next cycle; simultaneous halt=1 and resume=1 in HALT SHALL stay in HALT.
REQ-028 fetch_count SHALL increment by 1 each cycle fetch_valid=1 and saturate at 16'hFFFF with no wrap.
REQ-029 With ADDR_W=6, redirect_addr covers 0..63; no arithmetic is performed on addresses.

Reset
REQ-030 Reset SHALL act at the clock edge only: state=BOOT, boot counter=0, flush counter=0, fetch_count=0.
REQ-031 Reset asserted mid-FLUSH or mid-HALT SHALL abandon the operation; the next cycle is BOOT with outputs per REQ-021.
REQ-032 While reset=1, outputs SHALL follow BOOT values: pc_enable=0, rom_flush=1, fetch_valid=0 and pc_select=0.

Structure
REQ-033 State encodings, the default FLUSH_CYCLES/BOOT_CYCLES values, and the PC loader select encoding (0=sequential, 1=jump) SHALL live in the shared define file alongside MemAddr and DataSize.
REQ-034 The block SHALL be a single FSM plus counters; one sub-module, fetch_bubble_cnt (the loadable 4-bit down-counter), is permitted.
REQ-035 The block SHALL instantiate neither the PC loader nor the ROM; the top level wires them together.

Verification
REQ-036 Boot: assert reset 2 cycles, then release -> BOOT_CYCLES=1 cycle with rom_flush=1, then RUN with pc_enable=1 and fetch_valid=1; fetch_count=0 at release.
REQ-037 Redirect: in RUN, redirect=1 and redirect_addr=6'd40 for 1 cycle -> that cycle pc_select=1 and pc_jump_addr=40; next 2 cycles rom_flush=1 and fetch_valid=0; then RUN.
REQ-038 Stall in FLUSH: redirect, then stall=1 for 3 cycles -> FLUSH lasts 2+3 cycles, pc_enable=0 during the stall.
REQ-039 Back-to-back redirect: redirect to 10, then to 20 on the next cycle -> counter restarts, the PC loads 20, exactly 2 bubbles follow the second redirect.
REQ-040 Halt/resume: halt=1 in RUN -> HALT, pc_enable=0; halt=1 and resume=1 together -> stays in HALT; resume alone -> RUN next cycle; redirect with halt in the same cycle -> FLUSH.
REQ-041 Saturation and reset: preload or run fetch_count to 16'hFFFF -> it holds; reset mid-FLUSH -> BOOT and fetch_count=0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared fetch definitions: state encodings, defaults, PC loader select
package fetch_ctrl_pkg;

  localparam int MemAddr  = 6;
  localparam int DataSize = 32;

  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int DEF_BOOT_CYCLES  = 1;

  localparam logic PC_SEL_SEQ  = 1'b0;
  localparam logic PC_SEL_JUMP = 1'b1;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_bubble_cnt.sv
// rtl/fetch_bubble_cnt.sv - loadable 4-bit down-counter timing the post-redirect bubbles
module fetch_bubble_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencing FSM driving the PC loader and instruction ROM flush
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W       = MemAddr,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int BOOT_CYCLES  = DEF_BOOT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  input  logic              resume,
  output logic              pc_enable,
  output logic              pc_select,
  output logic [ADDR_W-1:0] pc_jump_addr,
  output logic              rom_flush,
  output logic              fetch_valid,
  output logic [15:0]       fetch_count,
  output logic [1:0]        state_o
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);

  fetch_state_t state, state_n;
  logic [3:0]   boot_cnt;
  logic         flush_load, flush_dec, flush_zero;

  fetch_bubble_cnt u_bubble (
    .clk      (clk),
    .reset    (reset),
    .load     (flush_load),
    .load_val (FLUSH_INIT),
    .dec      (flush_dec),
    .zero     (flush_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BOOT;
      boot_cnt    <= 4'd0;
      fetch_count <= 16'd0;
    end else begin
      state <= state_n;
      if (state == ST_BOOT && boot_cnt != BOOT_LAST) begin
        boot_cnt <= boot_cnt + 4'd1;
      end
      if (fetch_valid && fetch_count != 16'hFFFF) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

  // redirect outranks halt, halt outranks resume, resume outranks stall
  always_comb begin
    state_n    = state;
    flush_load = 1'b0;
    flush_dec  = 1'b0;
    case (state)
      ST_BOOT: begin
        if (boot_cnt == BOOT_LAST) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          state_n    = ST_FLUSH;
          flush_load = 1'b1;
        end else if (halt) begin
          state_n = ST_HALT;
        end
      end
      ST_FLUSH: begin
        if (redirect) begin
          flush_load = 1'b1;
        end else if (halt) begin
          state_n = ST_HALT;
        end else if (!stall) begin
          if (flush_zero) state_n = ST_RUN;
          else flush_dec = 1'b1;
        end
      end
      ST_HALT: begin
        if (redirect) begin
          state_n    = ST_FLUSH;
          flush_load = 1'b1;
        end else if (!halt && resume) begin
          state_n = ST_RUN;
        end
      end
      default: state_n = ST_BOOT;
    endcase
  end

  // reset forces the BOOT output values even before the first edge
  always_comb begin
    pc_enable   = 1'b0;
    pc_select   = PC_SEL_SEQ;
    rom_flush   = 1'b1;
    fetch_valid = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN, ST_FLUSH, ST_HALT: begin
          if (redirect) begin
            pc_enable = 1'b1;
            pc_select = PC_SEL_JUMP;
          end else if (state == ST_RUN && !halt) begin
            pc_enable   = ~stall;
            rom_flush   = 1'b0;
            fetch_valid = ~stall;
          end else if (state == ST_FLUSH && !halt) begin
            pc_enable = ~stall;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_jump_addr = redirect_addr;
  assign state_o      = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, halt, resume;
  logic [5:0]  redirect_addr;
  logic        pc_enable, pc_select, rom_flush, fetch_valid;
  logic [5:0]  pc_jump_addr;
  logic [15:0] fetch_count;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst, stl, rdr;
    logic [5:0]  addr;
    logic        hlt, rsm;
    logic        en, sel, fl, vld;
    logic [1:0]  st;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .resume        (resume),
    .pc_enable     (pc_enable),
    .pc_select     (pc_select),
    .pc_jump_addr  (pc_jump_addr),
    .rom_flush     (rom_flush),
    .fetch_valid   (fetch_valid),
    .fetch_count   (fetch_count),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic rst, stl, rdr, input logic [5:0] addr, input logic hlt, rsm,
                              input logic en, sel, fl, vld, input logic [1:0] st, input logic [15:0] cnt);
    vec_t v;
    v = '{rst, stl, rdr, addr, hlt, rsm, en, sel, fl, vld, st, cnt};
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 6'd0; halt = 1'b0; resume = 1'b0;

    //  rst stl rdr addr hlt rsm | en sel fl vld st cnt
    add(1, 0, 0, 6'd0,  0, 0,  0, 0, 1, 0, 0, 0);   // reset cycles
    add(1, 0, 0, 6'd0,  0, 0,  0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 6'd5,  1, 0,  0, 0, 1, 0, 0, 0);   // boot ignores inputs
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 0, 1, 1, 0);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 0, 1, 1, 1);
    add(0, 1, 0, 6'd0,  0, 0,  0, 0, 0, 0, 1, 2);   // stall in run
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 0, 1, 1, 2);
    add(0, 1, 1, 6'd40, 0, 0,  1, 1, 1, 0, 1, 3);   // redirect, stall ignored
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 1, 0, 2, 3);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 1, 0, 2, 3);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 0, 1, 1, 3);
    add(0, 0, 1, 6'd63, 0, 0,  1, 1, 1, 0, 1, 4);   // redirect then stall in flush
    add(0, 1, 0, 6'd0,  0, 0,  0, 0, 1, 0, 2, 4);
    add(0, 1, 0, 6'd0,  0, 0,  0, 0, 1, 0, 2, 4);
    add(0, 1, 0, 6'd0,  0, 0,  0, 0, 1, 0, 2, 4);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 1, 0, 2, 4);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 1, 0, 2, 4);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 0, 1, 1, 4);
    add(0, 0, 1, 6'd10, 0, 0,  1, 1, 1, 0, 1, 5);   // back-to-back redirect
    add(0, 0, 1, 6'd20, 0, 0,  1, 1, 1, 0, 2, 5);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 1, 0, 2, 5);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 1, 0, 2, 5);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 0, 1, 1, 5);
    add(0, 0, 0, 6'd0,  1, 0,  0, 0, 1, 0, 1, 6);   // halt
    add(0, 0, 0, 6'd0,  1, 1,  0, 0, 1, 0, 3, 6);
    add(0, 0, 0, 6'd0,  0, 0,  0, 0, 1, 0, 3, 6);
    add(0, 0, 0, 6'd0,  0, 1,  0, 0, 1, 0, 3, 6);
    add(0, 1, 0, 6'd0,  0, 0,  0, 0, 0, 0, 1, 6);
    add(0, 0, 1, 6'd0,  1, 0,  1, 1, 1, 0, 1, 6);   // redirect beats halt
    add(0, 0, 0, 6'd0,  1, 0,  0, 0, 1, 0, 2, 6);   // halt out of flush
    add(0, 0, 1, 6'd33, 1, 0,  1, 1, 1, 0, 3, 6);   // redirect out of halt
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 1, 0, 2, 6);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 1, 0, 2, 6);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 0, 1, 1, 6);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 0, 1, 1, 7);
    add(0, 0, 1, 6'd12, 0, 0,  1, 1, 1, 0, 1, 8);
    add(1, 0, 0, 6'd0,  0, 0,  0, 0, 1, 0, 2, 8);   // reset mid-flush
    add(0, 0, 0, 6'd0,  0, 0,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 6'd0,  0, 0,  1, 0, 0, 1, 1, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; stall = vecs[i].stl; redirect = vecs[i].rdr;
      redirect_addr = vecs[i].addr; halt = vecs[i].hlt; resume = vecs[i].rsm;
      #1;
      check("pc_enable",    i, 16'(pc_enable),    16'(vecs[i].en));
      check("pc_select",    i, 16'(pc_select),    16'(vecs[i].sel));
      check("pc_jump_addr", i, 16'(pc_jump_addr), 16'(vecs[i].addr));
      check("rom_flush",    i, 16'(rom_flush),    16'(vecs[i].fl));
      check("fetch_valid",  i, 16'(fetch_valid),  16'(vecs[i].vld));
      check("state_o",      i, 16'(state_o),      16'(vecs[i].st));
      check("fetch_count",  i, fetch_count,       vecs[i].cnt);
    end

    // free-running RUN from count 0 up to and past saturation
    repeat (65534) @(negedge clk);
    #1;
    check("count_fffe", 0, fetch_count, 16'hFFFE);
    @(negedge clk);
    #1;
    check("count_ffff", 0, fetch_count, 16'hFFFF);
    repeat (5) @(negedge clk);
    #1;
    check("count_hold", 0, fetch_count, 16'hFFFF);
    check("valid_sat",  0, 16'(fetch_valid), 16'd1);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("count_rst", 0, fetch_count, 16'h0000);
    check("state_rst", 0, 16'(state_o), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
